// File: rtl/systolic_drain.sv
`default_nettype none
// systolic_drain: de-skews the bottom-edge column outputs of an NxN systolic array into rows and
// buffers them in a row FIFO with valid/ready egress. Define DRAIN_SAT_EN to clamp elements to OUT_W bits.
module systolic_drain #(
  parameter int N     = 4,
  parameter int ACC_W = 16,
  parameter int DEPTH = 8,
  parameter int ROWS  = 4,
  parameter int OUT_W = 8
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [N*ACC_W-1:0] psum_in,
  input  logic [N-1:0]       psum_vld,
  output logic [N*ACC_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               stall_req,
  output logic               err_skew,
  output logic               err_ovf,
  input  logic               err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [ACC_W-1:0]   w_al_data [N];
  logic [N-1:0]       w_al_vld;
  logic [N*ACC_W-1:0] w_wr_row;

  genvar gj;
  generate
    for (gj = 0; gj < N; gj++) begin : g_col
      localparam int STAGES = N - 1 - gj;
      if (STAGES == 0) begin : g_pass
        assign w_al_data[gj] = psum_in[gj*ACC_W +: ACC_W];
        assign w_al_vld[gj]  = psum_vld[gj];
      end else begin : g_dly
        logic [ACC_W-1:0]  r_dat [STAGES];
        logic [STAGES-1:0] r_vld;
        // Data is reset along with valid so nothing undefined can reach the FIFO.
        always_ff @(posedge clk or negedge rst_b) begin
          if (!rst_b) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) r_dat[k] <= '0;
          end else begin
            r_vld[0] <= psum_vld[gj];
            r_dat[0] <= psum_in[gj*ACC_W +: ACC_W];
            for (int k = 1; k < STAGES; k++) begin
              r_vld[k] <= r_vld[k-1];
              r_dat[k] <= r_dat[k-1];
            end
          end
        end
        assign w_al_data[gj] = r_dat[STAGES-1];
        assign w_al_vld[gj]  = r_vld[STAGES-1];
      end
    end
  endgenerate

  genvar gk;
  generate
    for (gk = 0; gk < N; gk++) begin : g_wr
`ifdef DRAIN_SAT_EN
      localparam logic [ACC_W-1:0] c_sat_max = ACC_W'((1 << OUT_W) - 1);
      assign w_wr_row[gk*ACC_W +: ACC_W] = (w_al_data[gk] > c_sat_max) ? c_sat_max : w_al_data[gk];
`else
      assign w_wr_row[gk*ACC_W +: ACC_W] = w_al_data[gk];
`endif
    end
  endgenerate

  logic [N*ACC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [ROW_W-1:0]   r_row_cnt;
  logic               r_stall, r_err_skew, r_err_ovf;
  logic               w_row_all, w_row_mixed, w_full, w_pop, w_push, w_drop;

  always_comb begin
    w_row_all   = &w_al_vld;
    w_row_mixed = (|w_al_vld) & ~w_row_all;
    w_full      = (r_count == CNT_W'(DEPTH));
    w_pop       = out_valid & out_ready;
    w_push      = w_row_all & (~w_full | w_pop);
    w_drop      = w_row_all & w_full & ~w_pop;
    w_count_nxt = r_count;
    if (w_push & ~w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (~w_push & w_pop) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wr_row;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_row_cnt  <= '0;
      r_stall    <= 1'b0;
      r_err_skew <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) begin
        r_rptr    <= r_rptr + PTR_W'(1);
        r_row_cnt <= (r_row_cnt == ROW_W'(ROWS - 1)) ? '0 : r_row_cnt + ROW_W'(1);
      end
      r_count <= w_count_nxt;
      // Threshold leaves room for the N-1 rows still travelling through the delay lines.
      r_stall <= (w_count_nxt >= CNT_W'(DEPTH - N));
      if (w_row_mixed)  r_err_skew <= 1'b1;
      else if (err_clr) r_err_skew <= 1'b0;
      if (w_drop)       r_err_ovf  <= 1'b1;
      else if (err_clr) r_err_ovf  <= 1'b0;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rptr];
  assign out_last  = out_valid & (r_row_cnt == ROW_W'(ROWS - 1));
  assign stall_req = r_stall;
  assign err_skew  = r_err_skew;
  assign err_ovf   = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain.sv
`default_nettype none
// tb_systolic_drain: table vectors, directed corner sequences and randomized traffic against a queue model.
module tb_systolic_drain;
  localparam int N = 4, ACC_W = 16, DEPTH = 8, ROWS = 4, OUT_W = 8;
  localparam int W = N * ACC_W;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic [W-1:0] psum_in = '0;
  logic [N-1:0] psum_vld = '0;
  logic [W-1:0] out_data;
  logic         out_valid, out_ready = 1'b0, out_last, stall_req, err_skew, err_ovf;
  logic         err_clr = 1'b0;

  systolic_drain #(.N(N), .ACC_W(ACC_W), .DEPTH(DEPTH), .ROWS(ROWS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_b(rst_b), .psum_in(psum_in), .psum_vld(psum_vld),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .stall_req(stall_req), .err_skew(err_skew), .err_ovf(err_ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Stimulus scheduler: fut_*[k] is what the columns receive k cycles from now.
  logic [N-1:0]     fut_v [N];
  logic [ACC_W-1:0] fut_d [N][N];
  // Reference model: input history, row queue, tile position and flags.
  logic [N-1:0]     hist_v [N];
  logic [W-1:0]     hist_d [N];
  logic [W-1:0]     mq [$];
  int               m_rows;
  logic             m_skew, m_ovf, m_stall;

  typedef struct {
    logic [N-1:0] vld;
    logic         rdy;
    logic         clr;
    logic         ev;
    logic [W-1:0] ed;
    logic         es;
  } vec_t;
  vec_t tbl [18];

  function automatic vec_t mk(input logic [N-1:0] v, input logic r, input logic c,
                              input logic ev, input logic [W-1:0] ed, input logic es);
    vec_t t;
    t.vld = v; t.rdy = r; t.clr = c; t.ev = ev; t.ed = ed; t.es = es;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sat_row(input logic [W-1:0] r);
    logic [W-1:0] o;
    o = r;
`ifdef DRAIN_SAT_EN
    for (int j = 0; j < N; j++)
      if (o[j*ACC_W +: ACC_W] > ACC_W'((1 << OUT_W) - 1)) o[j*ACC_W +: ACC_W] = ACC_W'((1 << OUT_W) - 1);
`endif
    return o;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rows = 0; m_skew = 0; m_ovf = 0; m_stall = 0;
    for (int k = 0; k < N; k++) begin
      hist_v[k] = '0; hist_d[k] = '0; fut_v[k] = '0;
      for (int j = 0; j < N; j++) fut_d[k][j] = '0;
    end
  endtask

  task automatic check_model();
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) chk("out_data", out_data, mq[0]);
    chk("out_last", out_last, (mq.size() != 0) && (m_rows == ROWS - 1));
    chk("stall_req", stall_req, m_stall);
    chk("err_skew", err_skew, m_skew);
    chk("err_ovf", err_ovf, m_ovf);
  endtask

  // Column j seen at the aligned point is what entered N-1-j cycles earlier.
  task automatic model_edge(input logic [N-1:0] v, input logic [W-1:0] d, input logic rdy, input logic clr);
    logic [N-1:0] av;
    logic [W-1:0] ad;
    logic ovf_evt, skew_evt;
    for (int k = N - 1; k > 0; k--) begin hist_v[k] = hist_v[k-1]; hist_d[k] = hist_d[k-1]; end
    hist_v[0] = v; hist_d[0] = d;
    for (int j = 0; j < N; j++) begin
      av[j] = hist_v[N-1-j][j];
      ad[j*ACC_W +: ACC_W] = hist_d[N-1-j][j*ACC_W +: ACC_W];
    end
    ovf_evt = 0;
    skew_evt = (av != '0) && (av != '1);
    if (rdy && mq.size() != 0) begin
      void'(mq.pop_front());
      m_rows = (m_rows + 1) % ROWS;
    end
    if (av == '1) begin
      if (mq.size() < DEPTH) mq.push_back(sat_row(ad));
      else ovf_evt = 1;
    end
    m_skew  = skew_evt ? 1'b1 : (clr ? 1'b0 : m_skew);
    m_ovf   = ovf_evt  ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_stall = (mq.size() >= DEPTH - N);
  endtask

  task automatic launch(input logic [W-1:0] row);
    for (int j = 0; j < N; j++) begin
      fut_v[j][j] = 1'b1;
      fut_d[j][j] = row[j*ACC_W +: ACC_W];
    end
  endtask

  task automatic cycle(input logic rdy, input logic clr, input logic [N-1:0] extra);
    logic [N-1:0] v;
    logic [W-1:0] d;
    v = fut_v[0] | extra;
    for (int j = 0; j < N; j++) d[j*ACC_W +: ACC_W] = fut_d[0][j];
    psum_vld = v; psum_in = d; out_ready = rdy; err_clr = clr;
    check_model();
    model_edge(v, d, rdy, clr);
    for (int k = 0; k < N - 1; k++) begin
      fut_v[k] = fut_v[k+1];
      for (int j = 0; j < N; j++) fut_d[k][j] = fut_d[k+1][j];
    end
    fut_v[N-1] = '0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    #2 rst_b = 1'b0;
    #2 rst_b = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [W-1:0] rr;
    logic [N-1:0] ex;
    int pops;
    logic rdy;

    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    check_model();

    tbl[0]  = mk(4'b0001, 1, 0, 0, '0, 0);
    tbl[1]  = mk(4'b0010, 1, 0, 0, '0, 0);
    tbl[2]  = mk(4'b0100, 1, 0, 0, '0, 0);
    tbl[3]  = mk(4'b1000, 1, 0, 0, '0, 0);
    tbl[4]  = mk(4'b0000, 1, 0, 1, 64'h0040_0030_0020_0010, 0);
    tbl[5]  = mk(4'b0000, 1, 0, 0, '0, 0);
    tbl[6]  = mk(4'b1111, 1, 0, 0, '0, 0);
    tbl[7]  = mk(4'b0000, 1, 0, 0, '0, 1);
    tbl[8]  = mk(4'b0000, 1, 0, 0, '0, 1);
    tbl[9]  = mk(4'b0000, 1, 0, 0, '0, 1);
    tbl[10] = mk(4'b0000, 1, 1, 0, '0, 1);
    tbl[11] = mk(4'b0000, 1, 0, 0, '0, 0);
    tbl[12] = mk(4'b1111, 1, 0, 0, '0, 0);
    tbl[13] = mk(4'b0000, 1, 1, 0, '0, 1);
    tbl[14] = mk(4'b0000, 1, 1, 0, '0, 1);
    tbl[15] = mk(4'b0000, 1, 1, 0, '0, 1);
    tbl[16] = mk(4'b0000, 1, 1, 0, '0, 1);
    tbl[17] = mk(4'b0000, 1, 0, 0, '0, 0);
    for (int i = 0; i < 18; i++) begin
      for (int j = 0; j < N; j++) fut_d[0][j] = ACC_W'(16 * (j + 1));
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_skew", i), err_skew, tbl[i].es);
      cycle(tbl[i].rdy, tbl[i].clr, tbl[i].vld);
    end

    // Back-pressure: 8 rows fill the FIFO, a 9th is dropped, then drain in order.
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      launch({16'(i + 1), 16'(i + 1), 16'(i + 1), 16'(i + 1)});
      cycle(0, 0, '0);
    end
    repeat (3) cycle(0, 0, '0);
    chk("bp_stall", stall_req, 1'b1);
    chk("bp_ovf_before", err_ovf, 1'b0);
    launch(64'h0009_0009_0009_0009);
    repeat (4) cycle(0, 0, '0);
    chk("bp_ovf_after", err_ovf, 1'b1);
    repeat (12) cycle(1, 0, '0);
    chk("bp_drained", out_valid, 1'b0);

    // Tile framing with toggling ready.
    pulse_reset();
    pops = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 8) launch({$urandom(), $urandom()});
      rdy = (i % 2 == 0);
      if (out_valid && rdy) begin
        chk($sformatf("tile_last_pop%0d", pops), out_last, (pops % ROWS) == ROWS - 1);
        pops++;
      end
      cycle(rdy, 0, '0);
    end
    chk("tile_pops", 32'(pops), 32'd8);

    // Full FIFO with push and pop on the same edge.
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      launch({$urandom(), $urandom()});
      cycle(0, 0, '0);
    end
    repeat (3) cycle(0, 0, '0);
    launch(64'h1111_2222_3333_4444);
    repeat (3) cycle(0, 0, '0);
    cycle(1, 0, '0);
    repeat (2) cycle(0, 0, '0);
    chk("full_pp_ovf", err_ovf, 1'b0);
    chk("full_pp_valid", out_valid, 1'b1);
    repeat (12) cycle(1, 0, '0);

`ifdef DRAIN_SAT_EN
    pulse_reset();
    launch(64'h0000_0000_00FE_01FF);
    repeat (N) cycle(0, 0, '0);
    chk("sat_elems", {32'h0, out_data[31:0]}, 64'h0000_0000_00FE_00FF);
    repeat (2) cycle(1, 0, '0);
`endif

    // Reset mid-stream with flags set and rows in flight.
    pulse_reset();
    cycle(0, 0, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      launch({$urandom(), $urandom()});
      cycle(0, 0, '0);
    end
    cycle(0, 0, '0);
    chk("mid_pre_skew", err_skew, 1'b1);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_skew", err_skew, 1'b0);
    chk("mid_rst_ovf", err_ovf, 1'b0);
    chk("mid_rst_stall", stall_req, 1'b0);
    #2 rst_b = 1'b1;
    model_reset();
    repeat (8) cycle(1, 0, '0);

    // Randomized traffic, including skew faults, overflow and clears.
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        rr = {$urandom(), $urandom()};
        launch(rr);
      end
      ex = ($urandom_range(0, 24) == 0) ? N'($urandom()) : '0;
      cycle($urandom_range(0, 9) < 5, $urandom_range(0, 29) == 0, ex);
    end
    repeat (12) cycle(1, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
